// File: rtl/pedometer_sequencer_if.sv
// Request-side bundle: sensor sample stream plus host weight-configuration port.
// Latency: pure wiring, no storage.
// Backpressure: ready signals are driven by the sequencer (slave), valids and payloads by the requesters (master).
interface pedometer_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              smp_valid;
  logic              smp_ready;
  logic [DATA_W-1:0] smp_a;
  logic [DATA_W-1:0] smp_b;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_dual;
  logic [ADDR_W-1:0] cfg_addr1;
  logic [DATA_W-1:0] cfg_data1;
  logic [ADDR_W-1:0] cfg_addr2;
  logic [DATA_W-1:0] cfg_data2;
  logic              cfg_err;

  modport master (
    output smp_valid, smp_a, smp_b,
    output cfg_valid, cfg_dual, cfg_addr1, cfg_data1, cfg_addr2, cfg_data2,
    input  smp_ready, cfg_ready, cfg_err
  );

  modport slave (
    input  smp_valid, smp_a, smp_b,
    input  cfg_valid, cfg_dual, cfg_addr1, cfg_data1, cfg_addr2, cfg_data2,
    output smp_ready, cfg_ready, cfg_err
  );
endinterface

// File: rtl/pedometer_sequencer.sv
// Pedometer core front end: arbitrates samples vs weight writes, sequences core commands, accumulates steps.
// Latency: strobe in the cycle after accept; ready again EX_LATENCY+2 (count), 3 (weight), 2 (rejected cfg) cycles after the accept cycle.
// Backpressure: both readies low while a command is in flight; the arbitration loser sees ready low in a contended cycle.
module pedometer_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int NUM_WEIGHTS = 6,
  parameter int STEP_W      = 8,
  parameter int EX_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  pedometer_sequencer_if.slave req,
  input  logic              clear_steps,
  output logic              core_count_steps,
  output logic              core_update_weight,
  output logic              core_dual_update,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [ADDR_W-1:0] core_addr1,
  output logic [DATA_W-1:0] core_data1,
  output logic [ADDR_W-1:0] core_addr2,
  output logic [DATA_W-1:0] core_data2,
  input  logic              core_step,
  output logic [STEP_W-1:0] total_steps,
  output logic              steps_sat,
  output logic              busy
);

  localparam int CNT_W = (EX_LATENCY > 1) ? $clog2(EX_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(EX_LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [STEP_W-1:0] STEP_ONE = 1;
  localparam logic [ADDR_W:0]   NUM_LIM  = (ADDR_W + 1)'(NUM_WEIGHTS);

  typedef enum logic [2:0] {
    IDLE, CNT_ISSUE, CNT_WAIT, W_ISSUE, W_SETTLE, ERR
  } state_t;

  state_t            state, state_nxt;
  logic              last_cfg;   // 1 when the host port took the most recent grant
  logic              dual_q;     // captured cfg_dual of the accepted weight command
  logic [CNT_W-1:0]  wait_cnt;
  logic              idle;
  logic              smp_acc;
  logic              cfg_acc;
  logic              cfg_ok;
  logic              wait_done;

  // Arbitration: on contention the requester that did not win last time goes first.
  assign idle          = (state == IDLE);
  assign req.smp_ready = idle & (~req.cfg_valid | last_cfg);
  assign req.cfg_ready = idle & (~req.smp_valid | ~last_cfg);
  assign smp_acc       = req.smp_valid & req.smp_ready;
  assign cfg_acc       = req.cfg_valid & req.cfg_ready;
  assign wait_done     = (state == CNT_WAIT) && (wait_cnt == '0);

  // A weight write is legal only to existing registers, and a dual write must target two distinct ones.
  assign cfg_ok = ({1'b0, req.cfg_addr1} < NUM_LIM) &&
                  (!req.cfg_dual ||
                   (({1'b0, req.cfg_addr2} < NUM_LIM) && (req.cfg_addr2 != req.cfg_addr1)));

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs; each strobe maps to exactly one state so they never overlap.
  always_comb begin
    state_nxt          = state;
    core_count_steps   = 1'b0;
    core_update_weight = 1'b0;
    core_dual_update   = 1'b0;
    req.cfg_err        = 1'b0;
    busy               = (state != IDLE);
    case (state)
      IDLE: begin
        if (smp_acc)      state_nxt = CNT_ISSUE;
        else if (cfg_acc) state_nxt = cfg_ok ? W_ISSUE : ERR;
      end
      CNT_ISSUE: begin
        core_count_steps = 1'b1;
        state_nxt        = CNT_WAIT;
      end
      CNT_WAIT: begin
        if (wait_done) state_nxt = IDLE;
      end
      W_ISSUE: begin
        core_update_weight = ~dual_q;
        core_dual_update   = dual_q;
        state_nxt          = W_SETTLE;
      end
      W_SETTLE: state_nxt = IDLE;
      ERR: begin
        req.cfg_err = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Execute-latency counter: loaded alongside the count strobe, runs down through CNT_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == CNT_ISSUE) begin
      wait_cnt <= CNT_LOAD;
    end else if (state == CNT_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - CNT_ONE;
    end
  end

  // Operand capture on acceptance; values stay put until the next acceptance of the same kind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_a     <= '0;
      core_b     <= '0;
      core_addr1 <= '0;
      core_data1 <= '0;
      core_addr2 <= '0;
      core_data2 <= '0;
      dual_q     <= 1'b0;
      last_cfg   <= 1'b0;
    end else if (smp_acc) begin
      core_a   <= req.smp_a;
      core_b   <= req.smp_b;
      last_cfg <= 1'b0;
    end else if (cfg_acc) begin
      core_addr1 <= req.cfg_addr1;
      core_data1 <= req.cfg_data1;
      core_addr2 <= req.cfg_addr2;
      core_data2 <= req.cfg_data2;
      dual_q     <= req.cfg_dual;
      last_cfg   <= 1'b1;
    end
  end

  // Step accumulator: saturates at all-ones with a sticky flag; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_steps <= '0;
      steps_sat   <= 1'b0;
    end else if (clear_steps) begin
      total_steps <= '0;
      steps_sat   <= 1'b0;
    end else if (wait_done && core_step) begin
      if (&total_steps) steps_sat   <= 1'b1;
      else              total_steps <= total_steps + STEP_ONE;
    end
  end

endmodule

// File: tb/tb_pedometer_sequencer.sv
// Bench for pedometer_sequencer: directed stimulus with a scoreboard of expected core commands.
// Latency: checks strobe timing and ready-return cycles against hand-computed values.
// Backpressure: requesters hold valid until ready; the monitor checks one accept per cycle.
module tb_pedometer_sequencer;
  localparam int DATA_W = 8, ADDR_W = 3, NUM_WEIGHTS = 6, STEP_W = 8, EX_LATENCY = 2;

  typedef struct {
    int         kind;   // 0 count, 1 single write, 2 dual write, 3 cfg error
    logic [7:0] a, b, d1, d2;
    logic [2:0] a1, a2;
  } ev_t;

  logic clk;
  logic reset;
  logic clear_steps;
  logic core_count_steps, core_update_weight, core_dual_update;
  logic [DATA_W-1:0] core_a, core_b, core_data1, core_data2;
  logic [ADDR_W-1:0] core_addr1, core_addr2;
  logic core_step;
  logic [STEP_W-1:0] total_steps;
  logic steps_sat, busy;

  pedometer_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) req_if ();

  pedometer_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WEIGHTS(NUM_WEIGHTS),
    .STEP_W(STEP_W), .EX_LATENCY(EX_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .req(req_if), .clear_steps(clear_steps),
    .core_count_steps(core_count_steps), .core_update_weight(core_update_weight),
    .core_dual_update(core_dual_update), .core_a(core_a), .core_b(core_b),
    .core_addr1(core_addr1), .core_data1(core_data1),
    .core_addr2(core_addr2), .core_data2(core_data2),
    .core_step(core_step), .total_steps(total_steps),
    .steps_sat(steps_sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic step_plan = 1'b0;
  int   exp_total = 0;
  logic exp_sat = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic ev_t mk_ev(input int kind, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] a1, input logic [7:0] d1,
                                input logic [2:0] a2, input logic [7:0] d2);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.a1 = a1; e.d1 = d1; e.a2 = a2; e.d2 = d2;
    return e;
  endfunction

  // Core model: presents the planned step result EX_LATENCY cycles after the count strobe.
  initial begin
    core_step = 1'b0;
    forever begin
      @(negedge clk);
      if (core_count_steps) begin
        repeat (EX_LATENCY) @(posedge clk);
        #1 core_step = step_plan;
        @(posedge clk);
        #1 core_step = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every command/error output and checks accept exclusivity.
  always @(negedge clk) begin
    int  kind;
    int  nstb;
    logic acc_s, acc_c;
    ev_t e;
    acc_s = req_if.smp_valid & req_if.smp_ready;
    acc_c = req_if.cfg_valid & req_if.cfg_ready;
    if (acc_s | acc_c) check("one_accept_per_cycle", {31'd0, acc_s & acc_c}, 32'd0);
    nstb = int'(core_count_steps) + int'(core_update_weight) + int'(core_dual_update) + int'(req_if.cfg_err);
    if (nstb != 0) begin
      check("strobe_exclusive", nstb, 1);
      kind = core_count_steps ? 0 : core_update_weight ? 1 : core_dual_update ? 2 : 3;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == e.kind) begin
          case (kind)
            0: begin check("core_a", core_a, e.a); check("core_b", core_b, e.b); end
            1: begin check("core_addr1", core_addr1, e.a1); check("core_data1", core_data1, e.d1); end
            2: begin
              check("core_addr1", core_addr1, e.a1); check("core_data1", core_data1, e.d1);
              check("core_addr2", core_addr2, e.a2); check("core_data2", core_data2, e.d2);
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    req_if.smp_valid = 1'b0; req_if.cfg_valid = 1'b0;
    clear_steps = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_total = 0;
    exp_sat = 1'b0;
  endtask

  task automatic send_smp(input logic [7:0] a, input logic [7:0] b, input logic step,
                          input int clear_k, input bit chk_lat);
    bit got = 0;
    int strobe_k = 0;
    int ready_k = 0;
    step_plan = step;
    @(posedge clk);
    #1 req_if.smp_valid = 1'b1; req_if.smp_a = a; req_if.smp_b = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_if.smp_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL smp_accept_timeout: got no ready expected ready");
      req_if.smp_valid = 1'b0;
      return;
    end
    exp_q.push_back(mk_ev(0, a, b, 3'd0, 8'd0, 3'd0, 8'd0));
    if (step) begin
      if (exp_total == 255) exp_sat = 1'b1;
      else exp_total++;
    end
    if (clear_k > 0) begin exp_total = 0; exp_sat = 1'b0; end
    @(posedge clk);
    #1 req_if.smp_valid = 1'b0;
    for (int k = 1; k <= 12 && ready_k == 0; k++) begin
      clear_steps = (k == clear_k);
      @(negedge clk);
      if (core_count_steps && strobe_k == 0) strobe_k = k;
      if (req_if.smp_ready) ready_k = k;
      else begin @(posedge clk); #1; end
    end
    clear_steps = 1'b0;
    if (chk_lat) begin
      check("count_strobe_cycle", strobe_k, 1);
      check("smp_ready_return", ready_k, EX_LATENCY + 2);
      check("core_a_held", core_a, a);
    end else if (ready_k == 0) begin
      checks++; failures++;
      $display("FAIL smp_ready_timeout: got no ready expected ready");
    end
    check("total_steps", total_steps, exp_total);
    check("steps_sat", steps_sat, exp_sat);
  endtask

  task automatic send_cfg(input logic dual, input logic [2:0] a1, input logic [7:0] d1,
                          input logic [2:0] a2, input logic [7:0] d2, input int kind, input int ret);
    bit got = 0;
    int ready_k = 0;
    @(posedge clk);
    #1 req_if.cfg_valid = 1'b1; req_if.cfg_dual = dual;
    req_if.cfg_addr1 = a1; req_if.cfg_data1 = d1; req_if.cfg_addr2 = a2; req_if.cfg_data2 = d2;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_if.cfg_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL cfg_accept_timeout: got no ready expected ready");
      req_if.cfg_valid = 1'b0;
      return;
    end
    exp_q.push_back(mk_ev(kind, 8'd0, 8'd0, a1, d1, a2, d2));
    @(posedge clk);
    #1 req_if.cfg_valid = 1'b0;
    for (int k = 1; k <= 10 && ready_k == 0; k++) begin
      @(negedge clk);
      if (req_if.cfg_ready) ready_k = k;
      else begin @(posedge clk); #1; end
    end
    check("cfg_ready_return", ready_k, ret);
  endtask

  initial begin
    int order[4];
    int n;
    bit idle_seen;
    logic acc_s, acc_c;
    reset = 1'b0; clear_steps = 1'b0;
    req_if.smp_valid = 1'b0; req_if.smp_a = '0; req_if.smp_b = '0;
    req_if.cfg_valid = 1'b0; req_if.cfg_dual = 1'b0;
    req_if.cfg_addr1 = '0; req_if.cfg_data1 = '0; req_if.cfg_addr2 = '0; req_if.cfg_data2 = '0;

    // Reset state
    @(negedge clk);
    check("rst_total", total_steps, 0);
    check("rst_sat", steps_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_count", core_count_steps, 0);
    check("rst_cfg_err", req_if.cfg_err, 0);
    check("rst_core_a", core_a, 0);
    check("rst_smp_ready", req_if.smp_ready, 1);
    check("rst_cfg_ready", req_if.cfg_ready, 1);
    do_reset();

    // Single sample with a detected step
    send_smp(8'h40, 8'h10, 1'b1, 0, 1'b1);

    // Weight writes: legal dual, out-of-range single, dual to the same address
    send_cfg(1'b1, 3'd2, 8'h33, 3'd5, 8'h7F, 2, 3);
    send_cfg(1'b0, 3'd1, 8'h21, 3'd0, 8'h00, 1, 3);
    send_cfg(1'b0, 3'd6, 8'h44, 3'd0, 8'h00, 3, 2);
    send_cfg(1'b1, 3'd3, 8'h55, 3'd3, 8'h66, 3, 2);
    check("cmds_no_step_change", total_steps, 1);

    // Contention from reset: grants alternate starting with cfg
    do_reset();
    order = '{1, 0, 1, 0};
    step_plan = 1'b0;
    @(posedge clk);
    #1 req_if.smp_valid = 1'b1; req_if.smp_a = 8'h11; req_if.smp_b = 8'h22;
    req_if.cfg_valid = 1'b1; req_if.cfg_dual = 1'b0; req_if.cfg_addr1 = 3'd1; req_if.cfg_data1 = 8'h55;
    for (int i = 0; i < 4; i++) begin
      if (order[i] == 1) exp_q.push_back(mk_ev(1, 8'd0, 8'd0, 3'd1, 8'h55, 3'd0, 8'd0));
      else               exp_q.push_back(mk_ev(0, 8'h11, 8'h22, 3'd0, 8'd0, 3'd0, 8'd0));
    end
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      acc_s = req_if.smp_valid & req_if.smp_ready;
      acc_c = req_if.cfg_valid & req_if.cfg_ready;
      if (acc_s | acc_c) begin
        check("grant_order", {31'd0, acc_c}, order[n]);
        n++;
        if (n == 4) begin
          @(posedge clk);
          #1 req_if.smp_valid = 1'b0; req_if.cfg_valid = 1'b0;
        end
      end
    end
    if (n < 4) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got %0d grants expected 4", n);
      req_if.smp_valid = 1'b0; req_if.cfg_valid = 1'b0;
    end
    idle_seen = 0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      @(negedge clk);
      if (!busy) idle_seen = 1;
    end
    check("contention_idle", {31'd0, idle_seen}, 1);
    check("contention_total", total_steps, 0);

    // Saturation: 254 steps to FE, then two more
    for (int i = 0; i < 254; i++) send_smp(i[7:0], 8'h01, 1'b1, 0, 1'b0);
    check("preload_fe", total_steps, 8'hFE);
    send_smp(8'hA0, 8'hA1, 1'b1, 0, 1'b1);
    send_smp(8'hB0, 8'hB1, 1'b1, 0, 1'b1);
    check("sat_total", total_steps, 8'hFF);
    check("sat_flag", steps_sat, 1);
    send_smp(8'hC0, 8'hC1, 1'b0, 0, 1'b1);
    @(posedge clk);
    #1 clear_steps = 1'b1;
    @(posedge clk);
    #1 clear_steps = 1'b0;
    exp_total = 0; exp_sat = 1'b0;
    @(negedge clk);
    check("clear_total", total_steps, 0);
    check("clear_sat", steps_sat, 0);

    // Clear coinciding with an increment
    send_smp(8'h01, 8'h02, 1'b1, 0, 1'b1);
    send_smp(8'h03, 8'h04, 1'b1, 3, 1'b1);

    // Reset in the middle of CNT_WAIT
    send_smp(8'h05, 8'h06, 1'b1, 0, 1'b1);
    step_plan = 1'b1;
    @(posedge clk);
    #1 req_if.smp_valid = 1'b1; req_if.smp_a = 8'h77; req_if.smp_b = 8'h88;
    @(negedge clk);
    check("abort_accept_ready", req_if.smp_ready, 1);
    exp_q.push_back(mk_ev(0, 8'h77, 8'h88, 3'd0, 8'd0, 3'd0, 8'd0));
    @(posedge clk);
    #1 req_if.smp_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_total", total_steps, 0);
    check("abort_core_a", core_a, 0);
    check("abort_ready", req_if.smp_ready, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(negedge clk);
    check("post_abort_total", total_steps, 0);
    check("post_abort_busy", busy, 0);
    check("post_abort_ready", req_if.smp_ready, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
